// File: rtl/impulse_accumulator.sv
// Impulse accumulator: sums per-body velocity/position deltas from resolved contacts
// over a physics frame, then drains one saturated delta record per body to the integrator.
module impulse_accumulator #(
    parameter int unsigned N_BODIES = 8,
    parameter int unsigned W        = 32,
    localparam int unsigned BW      = $clog2(N_BODIES)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_body_a,
    input  logic [BW-1:0] in_body_b,
    input  logic [W-1:0]  in_impulse_x,
    input  logic [W-1:0]  in_impulse_y,
    input  logic [W-1:0]  in_nudge_x,
    input  logic [W-1:0]  in_nudge_y,
    input  logic          frame_end,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_body,
    output logic [W-1:0]  out_dvel_x,
    output logic [W-1:0]  out_dvel_y,
    output logic [W-1:0]  out_dpos_x,
    output logic [W-1:0]  out_dpos_y,
    output logic          busy,
    output logic [7:0]    drop_count
);
    localparam logic [W-1:0]  MAX_V    = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  MIN_V    = {1'b1, {(W-1){1'b0}}};
    localparam logic [BW-1:0] LAST_IDX = BW'(N_BODIES - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [BW-1:0] drain_idx;
    logic [W-1:0]  dvel_x [N_BODIES];
    logic [W-1:0]  dvel_y [N_BODIES];
    logic [W-1:0]  dpos_x [N_BODIES];
    logic [W-1:0]  dpos_y [N_BODIES];
    logic          idx_ok;
    logic          rec_ok;
    logic          accept;
    logic          upd_en;
    logic          out_fire;

    // Signed W-bit add clamped to the representable range instead of wrapping.
    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1]) begin
            return s[W] ? MIN_V : MAX_V;
        end
        return s[W-1:0];
    endfunction

    // Negation where the most negative value maps to the most positive one.
    function automatic logic [W-1:0] sat_neg(input logic [W-1:0] b);
        return (b == MIN_V) ? MAX_V : (~b + W'(1));
    endfunction

    // Index range check is only needed when the index field can encode non-existent bodies.
    if ((2 ** BW) == N_BODIES) begin : g_idx_full
        assign idx_ok = 1'b1;
    end else begin : g_idx_range
        assign idx_ok = (32'(in_body_a) < N_BODIES) && (32'(in_body_b) < N_BODIES);
    end

    assign in_ready = (state == ACCUM);
    assign out_valid = (state == DRAIN);
    assign busy = (state == DRAIN);
    assign accept = in_valid && in_ready;
    assign rec_ok = idx_ok && (in_body_a != in_body_b);
    assign upd_en = accept && rec_ok;
    assign out_fire = out_valid && out_ready;

    assign out_body   = drain_idx;
    assign out_dvel_x = dvel_x[drain_idx];
    assign out_dvel_y = dvel_y[drain_idx];
    assign out_dpos_x = dpos_x[drain_idx];
    assign out_dpos_y = dpos_y[drain_idx];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM: begin
                if (frame_end) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && (drain_idx == LAST_IDX)) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            drain_idx <= '0;
        end else if (state == ACCUM) begin
            drain_idx <= '0;
        end else if (out_fire) begin
            drain_idx <= (drain_idx == LAST_IDX) ? '0 : drain_idx + BW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            drop_count <= '0;
        end else if (accept && !rec_ok && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    // Single-cycle read-modify-write; a and b never alias when the update is enabled.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < int'(N_BODIES); i++) begin
                dvel_x[i] <= '0;
                dvel_y[i] <= '0;
                dpos_x[i] <= '0;
                dpos_y[i] <= '0;
            end
        end else if (upd_en) begin
            dvel_x[in_body_a] <= sat_add(dvel_x[in_body_a], in_impulse_x);
            dvel_y[in_body_a] <= sat_add(dvel_y[in_body_a], in_impulse_y);
            dpos_x[in_body_a] <= sat_add(dpos_x[in_body_a], in_nudge_x);
            dpos_y[in_body_a] <= sat_add(dpos_y[in_body_a], in_nudge_y);
            dvel_x[in_body_b] <= sat_add(dvel_x[in_body_b], sat_neg(in_impulse_x));
            dvel_y[in_body_b] <= sat_add(dvel_y[in_body_b], sat_neg(in_impulse_y));
            dpos_x[in_body_b] <= sat_add(dpos_x[in_body_b], sat_neg(in_nudge_x));
            dpos_y[in_body_b] <= sat_add(dpos_y[in_body_b], sat_neg(in_nudge_y));
        end else if (out_fire) begin
            dvel_x[drain_idx] <= '0;
            dvel_y[drain_idx] <= '0;
            dpos_x[drain_idx] <= '0;
            dpos_y[drain_idx] <= '0;
        end
    end
endmodule

// File: tb/tb_impulse_accumulator.sv
// Bench for impulse_accumulator: table-driven contact frames against a saturating
// reference model, with a drain scoreboard and hand-written backpressure/reset sequences.
module tb_impulse_accumulator;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_body_a = '0;
    logic [2:0]  in_body_b = '0;
    logic [31:0] in_impulse_x = '0;
    logic [31:0] in_impulse_y = '0;
    logic [31:0] in_nudge_x = '0;
    logic [31:0] in_nudge_y = '0;
    logic        frame_end = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_body;
    logic [31:0] out_dvel_x;
    logic [31:0] out_dvel_y;
    logic [31:0] out_dpos_x;
    logic [31:0] out_dpos_y;
    logic        busy;
    logic [7:0]  drop_count;

    impulse_accumulator #(.N_BODIES(8), .W(32)) dut (
        .Clk(Clk), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_body_a(in_body_a), .in_body_b(in_body_b),
        .in_impulse_x(in_impulse_x), .in_impulse_y(in_impulse_y),
        .in_nudge_x(in_nudge_x), .in_nudge_y(in_nudge_y),
        .frame_end(frame_end),
        .out_valid(out_valid), .out_ready(out_ready), .out_body(out_body),
        .out_dvel_x(out_dvel_x), .out_dvel_y(out_dvel_y),
        .out_dpos_x(out_dpos_x), .out_dpos_y(out_dpos_y),
        .busy(busy), .drop_count(drop_count)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [2:0]  body;
        logic [31:0] dvx;
        logic [31:0] dvy;
        logic [31:0] dpx;
        logic [31:0] dpy;
    } rec_t;

    typedef struct {
        logic [2:0]  a;
        logic [2:0]  b;
        logic [31:0] ix;
        logic [31:0] iy;
        logic [31:0] nx;
        logic [31:0] ny;
        bit          fe;
        int          exp_drop;
    } row_t;

    localparam int N_ROWS = 8;

    rec_t        exp_q[$];
    row_t        tbl[N_ROWS];
    logic [31:0] m_dvx[8], m_dvy[8], m_dpx[8], m_dpy[8];
    logic [31:0] cap_dvx[128], cap_dvy[128], cap_dpx[128], cap_dpy[128];
    int          exp_drops = 0;
    int          fidx = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_add(input logic [31:0] x, input logic [31:0] y);
        longint s;
        s = longint'($signed(x)) + longint'($signed(y));
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return 32'(s);
    endfunction

    function automatic logic [31:0] m_neg(input logic [31:0] y);
        if (y == 32'h8000_0000) return 32'h7FFF_FFFF;
        return 32'(-longint'($signed(y)));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_dvx[i] = '0; m_dvy[i] = '0; m_dpx[i] = '0; m_dpy[i] = '0;
        end
    endtask

    task automatic model_apply(input logic [2:0] a, input logic [2:0] b,
                               input logic [31:0] ix, input logic [31:0] iy,
                               input logic [31:0] nx, input logic [31:0] ny);
        if (a == b) begin
            if (exp_drops < 255) exp_drops++;
        end else begin
            m_dvx[a] = m_add(m_dvx[a], ix); m_dvx[b] = m_add(m_dvx[b], m_neg(ix));
            m_dvy[a] = m_add(m_dvy[a], iy); m_dvy[b] = m_add(m_dvy[b], m_neg(iy));
            m_dpx[a] = m_add(m_dpx[a], nx); m_dpx[b] = m_add(m_dpx[b], m_neg(nx));
            m_dpy[a] = m_add(m_dpy[a], ny); m_dpy[b] = m_add(m_dpy[b], m_neg(ny));
        end
    endtask

    task automatic push_frame();
        rec_t r;
        for (int i = 0; i < 8; i++) begin
            r.body = 3'(i);
            r.dvx = m_dvx[i]; r.dvy = m_dvy[i]; r.dpx = m_dpx[i]; r.dpy = m_dpy[i];
            exp_q.push_back(r);
        end
        model_clear();
    endtask

    // Called at a negedge; drives one record (optionally with frame_end) for one cycle.
    task automatic send(input logic [2:0] a, input logic [2:0] b,
                        input logic [31:0] ix, input logic [31:0] iy,
                        input logic [31:0] nx, input logic [31:0] ny, input bit fe);
        in_valid = 1'b1; in_body_a = a; in_body_b = b;
        in_impulse_x = ix; in_impulse_y = iy; in_nudge_x = nx; in_nudge_y = ny;
        frame_end = fe;
        check("in_ready_accum", 32'(in_ready), 32'd1);
        model_apply(a, b, ix, iy, nx, ny);
        if (fe) push_frame();
        @(negedge Clk);
        in_valid = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic empty_frame();
        frame_end = 1'b1;
        push_frame();
        @(negedge Clk);
        frame_end = 1'b0;
    endtask

    // Consume n drain handshakes (n < 0: until the scoreboard is empty).
    task automatic drain_n(input int n);
        int   got = 0;
        int   cyc = 0;
        rec_t e;
        while (((n < 0) ? (exp_q.size() > 0) : (got < n)) && cyc < 100) begin
            out_ready = 1'b1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_record", 32'(out_body), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_body", 32'(out_body), 32'(e.body));
                    check("out_dvel_x", out_dvel_x, e.dvx);
                    check("out_dvel_y", out_dvel_y, e.dvy);
                    check("out_dpos_x", out_dpos_x, e.dpx);
                    check("out_dpos_y", out_dpos_y, e.dpy);
                    check("in_ready_drain", 32'(in_ready), 32'd0);
                    cap_dvx[fidx*8 + int'(out_body)] = out_dvel_x;
                    cap_dvy[fidx*8 + int'(out_body)] = out_dvel_y;
                    cap_dpx[fidx*8 + int'(out_body)] = out_dpos_x;
                    cap_dpy[fidx*8 + int'(out_body)] = out_dpos_y;
                end
                got++;
            end
            cyc++;
            @(negedge Clk);
        end
        out_ready = 1'b0;
        if (cyc >= 100) check("drain_timeout", 32'(got), 32'(n));
    endtask

    task automatic drain_all();
        drain_n(-1);
        check("busy_after_drain", 32'(busy), 32'd0);
        check("in_ready_after_drain", 32'(in_ready), 32'd1);
        check("out_valid_after_drain", 32'(out_valid), 32'd0);
        if (fidx < 15) fidx++;
    endtask

    initial begin
        logic [2:0]  ra, rb;
        logic [31:0] rv[4];

        // Frames: single contact; back-to-back shared body; saturation; invalid-only.
        tbl[0] = '{3'd0, 3'd1, 32'h0400_0000, 32'h0, 32'h0, 32'h0080_0000, 1'b1, 0};
        tbl[1] = '{3'd0, 3'd1, 32'h0100_0000, 32'h0, 32'h0, 32'h0, 1'b0, 0};
        tbl[2] = '{3'd1, 3'd2, 32'h0100_0000, 32'h0, 32'h0, 32'h0, 1'b1, 0};
        tbl[3] = '{3'd3, 3'd4, 32'h4000_0000, 32'h0, 32'h0, 32'h0, 1'b0, 0};
        tbl[4] = '{3'd3, 3'd4, 32'h4000_0000, 32'h0, 32'h0, 32'h0, 1'b0, 0};
        tbl[5] = '{3'd3, 3'd4, 32'h4000_0000, 32'h0000_1000, 32'h7FFF_FFFF, 32'hFFFF_FFFB, 1'b0, 0};
        tbl[6] = '{3'd5, 3'd6, 32'h8000_0000, 32'h0, 32'h0, 32'h8000_0000, 1'b1, 0};
        tbl[7] = '{3'd2, 3'd2, 32'h1234_5678, 32'h1, 32'h2, 32'h3, 1'b0, 1};
        model_clear();

        repeat (3) @(negedge Clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_out_dvel_x", out_dvel_x, 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < N_ROWS; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].ix, tbl[i].iy, tbl[i].nx, tbl[i].ny, tbl[i].fe);
            check("drop_count_row", 32'(drop_count), 32'(tbl[i].exp_drop));
            if (tbl[i].fe) drain_all();
        end
        // Second invalid record (a==b on body 1) closes the frame; nothing accumulated.
        send(3'd1, 3'd1, 32'h0400_0000, 32'h0, 32'h0, 32'h0, 1'b1);
        check("drop_count_two", 32'(drop_count), 32'd2);
        drain_all();

        check("f0_b0_dvx", cap_dvx[0], 32'h0400_0000);
        check("f0_b0_dpy", cap_dpy[0], 32'h0080_0000);
        check("f0_b1_dvx", cap_dvx[1], 32'hFC00_0000);
        check("f0_b1_dpy", cap_dpy[1], 32'hFF80_0000);
        check("f0_b7_dvx", cap_dvx[7], 32'h0);
        check("f1_b0_dvx", cap_dvx[8], 32'h0100_0000);
        check("f1_b1_dvx", cap_dvx[9], 32'h0);
        check("f1_b2_dvx", cap_dvx[10], 32'hFF00_0000);
        check("f2_b3_dvx", cap_dvx[19], 32'h7FFF_FFFF);
        check("f2_b4_dvx", cap_dvx[20], 32'h8000_0000);
        check("f2_b5_dvx", cap_dvx[21], 32'h8000_0000);
        check("f2_b6_dvx", cap_dvx[22], 32'h7FFF_FFFF);
        check("f2_b6_dpy", cap_dpy[22], 32'h7FFF_FFFF);
        check("f3_b1_dvx", cap_dvx[25], 32'h0);
        check("f3_b2_dvx", cap_dvx[26], 32'h0);

        // Backpressure at body 4 with contacts and frame_end offered mid-drain.
        send(3'd4, 3'd5, 32'h00AB_CDEF, 32'h11, 32'h22, 32'h33, 1'b1);
        drain_n(4);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_body", 32'(out_body), 32'd4);
            check("bp_out_dvel_x", out_dvel_x, exp_q[0].dvx);
            check("bp_out_dpos_y", out_dpos_y, exp_q[0].dpy);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            in_valid = 1'b1; in_body_a = 3'd0; in_body_b = 3'd1;
            in_impulse_x = 32'h0000_0001; in_impulse_y = '0; in_nudge_x = '0; in_nudge_y = '0;
            frame_end = (k == 2);
            @(negedge Clk);
        end
        in_valid = 1'b0;
        frame_end = 1'b0;
        drain_all();
        for (int k = 0; k < 4; k++) begin
            check("no_second_drain", 32'(out_valid), 32'd0);
            @(negedge Clk);
        end
        empty_frame();
        drain_all();

        // Random contacts, including occasional a==b drops.
        for (int k = 0; k < 8; k++) begin
            ra = 3'($urandom_range(0, 7));
            rb = 3'($urandom_range(0, 7));
            for (int j = 0; j < 4; j++) rv[j] = $urandom;
            send(ra, rb, rv[0], rv[1], rv[2], rv[3], k == 7);
        end
        check("drop_count_rand", 32'(drop_count), 32'(exp_drops));
        drain_all();

        // Reset after body 2 has drained.
        send(3'd2, 3'd3, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000, 1'b1);
        drain_n(3);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_drop_count", 32'(drop_count), 32'd0);
        exp_q.delete();
        model_clear();
        exp_drops = 0;
        empty_frame();
        drain_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
